// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen
// Description : Multi-channel LED driver. A shared prescaler tick drives each
//               channel's OFF/ON/BLINK/BREATHE pattern; mode and period are set
//               per channel through a one-cycle write port.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int CLK_FREQ_HZ    = 27_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int NUM_LEDS       = 6,
    parameter int PER_W          = 16,
    parameter int RESET_PERIOD   = 500,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_sel,
    input  logic [1:0]          cfg_mode,
    input  logic [PER_W-1:0]    cfg_period,
    output logic                tick_o,
    output logic [NUM_LEDS-1:0] led
);

    localparam int   DIV    = CLK_FREQ_HZ / TICK_HZ;
    localparam int   PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic ACT_LO = (LED_ACTIVE_LOW != 0);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ON      = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic                tick_q, tick_d;
    logic [7:0]          pwm_q, pwm_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [NUM_LEDS-1:0] lit_vec;

    // tick_q is high exactly while the prescaler sits at DIV-1
    always_comb begin
        presc_d = (presc_q == PRE_W'(DIV - 1)) ? '0 : presc_q + PRE_W'(1);
        tick_d  = (presc_d == PRE_W'(DIV - 1));
        pwm_d   = pwm_q + 8'd1;
        led_d   = lit_vec ^ {NUM_LEDS{ACT_LO}};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            pwm_q   <= 8'd0;
            led_q   <= {NUM_LEDS{ACT_LO}};
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
            led_q   <= led_d;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        localparam logic [3:0] CH_IDX = 4'(i);

        logic [1:0]       mode_q, mode_d;
        logic [PER_W-1:0] period_q, period_d;
        logic [PER_W-1:0] cnt_q, cnt_d;
        logic [PER_W-1:0] last_cnt;
        logic             state_q, state_d;
        logic [7:0]       duty_q, duty_d;
        logic             down_q, down_d;
        logic             wr, wrap, lit;

        always_comb begin
            mode_d   = mode_q;
            period_d = period_q;
            cnt_d    = cnt_q;
            state_d  = state_q;
            duty_d   = duty_q;
            down_d   = down_q;
            lit      = 1'b0;

            wr       = cfg_we && (cfg_sel == CH_IDX);
            // a zero period behaves as a period of one tick
            last_cnt = (period_q == '0) ? '0 : period_q - PER_W'(1);
            wrap     = tick_q && (cnt_q == last_cnt);

            if (wr) begin
                mode_d   = cfg_mode;
                period_d = cfg_period;
                cnt_d    = '0;
                state_d  = 1'b0;
                duty_d   = 8'd0;
                down_d   = 1'b0;
            end else if (wrap) begin
                cnt_d   = '0;
                state_d = ~state_q;
                if (!down_q) begin
                    if (duty_q == 8'd255) begin
                        down_d = 1'b1;
                        duty_d = 8'd254;
                    end else begin
                        duty_d = duty_q + 8'd1;
                    end
                end else begin
                    if (duty_q == 8'd0) begin
                        down_d = 1'b0;
                        duty_d = 8'd1;
                    end else begin
                        duty_d = duty_q - 8'd1;
                    end
                end
            end else if (tick_q) begin
                cnt_d = cnt_q + PER_W'(1);
            end

            case (mode_q)
                MODE_OFF:     lit = 1'b0;
                MODE_ON:      lit = 1'b1;
                MODE_BLINK:   lit = state_q;
                MODE_BREATHE: lit = (pwm_q < duty_q);
                default:      lit = 1'b0;
            endcase
        end

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                mode_q   <= MODE_BLINK;
                period_q <= PER_W'(RESET_PERIOD);
                cnt_q    <= '0;
                state_q  <= 1'b0;
                duty_q   <= 8'd0;
                down_q   <= 1'b0;
            end else begin
                mode_q   <= mode_d;
                period_q <= period_d;
                cnt_q    <= cnt_d;
                state_q  <= state_d;
                duty_q   <= duty_d;
                down_q   <= down_d;
            end
        end

        assign lit_vec[i] = lit;
    end

    assign tick_o = tick_q;
    assign led    = led_q;

endmodule
`default_nettype wire
